// File: rtl/add_sub_arbiter.sv
// add_sub_arbiter: round-robin sharing of one external ripple-carry add/sub among N requesters.
module add_sub_arbiter #(
  parameter int N       = 4,
  parameter int IDW     = 2,
  parameter int WIDTH   = 32,
  parameter int LATENCY = 2
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [N-1:0]       REQ,
  input  logic [N*WIDTH-1:0] REQ_A,
  input  logic [N*WIDTH-1:0] REQ_B,
  input  logic [N-1:0]       REQ_SnA,
  output logic [N-1:0]       GNT,
  output logic [WIDTH-1:0]   ADD_A,
  output logic [WIDTH-1:0]   ADD_B,
  output logic               ADD_SnA,
  input  logic [WIDTH-1:0]   ADD_Y,
  input  logic               ADD_CO,
  output logic [WIDTH-1:0]   Y,
  output logic               CO,
  output logic [IDW-1:0]     ID,
  output logic               DONE,
  output logic               BUSY
);
  localparam int CW = $clog2(LATENCY + 1);
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_CPLT} state_t;
  state_t state, next_state;
  logic [IDW-1:0] ptr, win;
  logic           found;
  logic [CW-1:0]  cnt;
  // first set request scanning upward from ptr, wrapping at N
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < N; i++)
      if (!found && REQ[(int'(ptr) + i) % N]) begin
        found = 1'b1;
        win   = IDW'((int'(ptr) + i) % N);
      end
  end
  always_ff @(posedge CLK or negedge RST)
    if (!RST) state <= S_IDLE;
    else      state <= next_state;
  always_comb
    next_state = state == S_IDLE ? (found ? S_BUSY : S_IDLE) :
                 state == S_BUSY ? (cnt == '0 ? S_CPLT : S_BUSY) : S_IDLE;
  always_comb BUSY = state != S_IDLE;
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      GNT     <= '0;
      ADD_A   <= '0;
      ADD_B   <= '0;
      ADD_SnA <= 1'b0;
      Y       <= '0;
      CO      <= 1'b0;
      ID      <= '0;
      DONE    <= 1'b0;
      ptr     <= '0;
      cnt     <= '0;
    end else begin
      GNT  <= '0;
      DONE <= 1'b0;
      if (state == S_IDLE && found) begin
        ADD_A   <= REQ_A[win*WIDTH +: WIDTH];
        ADD_B   <= REQ_B[win*WIDTH +: WIDTH];
        ADD_SnA <= REQ_SnA[win];
        ID      <= win;
        GNT     <= N'(1) << win;
        cnt     <= CW'(LATENCY - 1);
        ptr     <= IDW'((int'(win) + 1) % N);
      end
      if (state == S_BUSY) begin
        if (cnt != '0) cnt <= cnt - 1'b1;
        else begin
          Y    <= ADD_Y;
          CO   <= ADD_CO;
          DONE <= 1'b1;
        end
      end
    end
endmodule
